// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_pkg
// Description : ARP-over-Ethernet field constants, RX parser state encoding
//               and the per-byte fixed-header check used by arp_rx_parser.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

   localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
   localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  ARP_HLEN       = 8'd6;
   localparam logic [7:0]  ARP_PLEN       = 8'd4;
   localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
   localparam logic [15:0] ARP_OPER_REP   = 16'h0002;
   localparam int          ARP_BODY_LEN   = 28;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PARSE = 3'd1,
      PAD   = 3'd2,
      DROP  = 3'd3,
      CHECK = 3'd4
   } arp_rx_state_t;

   // True when byte 'b' at body offset 'idx' matches the fixed ARP header.
   // Offsets past the header (addresses) always pass.
   function automatic logic hdr_byte_ok(input logic [4:0] idx, input logic [7:0] b);
      case (idx)
         5'd0:    return b == ARP_HTYPE_ETH[15:8];
         5'd1:    return b == ARP_HTYPE_ETH[7:0];
         5'd2:    return b == ARP_PTYPE_IPV4[15:8];
         5'd3:    return b == ARP_PTYPE_IPV4[7:0];
         5'd4:    return b == ARP_HLEN;
         5'd5:    return b == ARP_PLEN;
         5'd6:    return b == ARP_OPER_REQ[15:8];
         5'd7:    return (b == ARP_OPER_REQ[7:0]) || (b == ARP_OPER_REP[7:0]);
         default: return 1'b1;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/arp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module      : arp_rx_parser
// Description : Byte-serial IPv4-over-Ethernet ARP body parser. Validates the
//               28-byte body, presents sender MAC/IP with a one-cycle strobe
//               and flags requests targeting the local IP.
// Revision    : 1.0 - initial release
// ============================================================================
module arp_rx_parser
   import eth_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [31:0]          ip_config_addr_in,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   input  logic                 s_axis_tuser,
   output logic [47:0]          arp_mac_s_addr,
   output logic [31:0]          arp_ip_s_addr,
   output logic                 arp_mac_s_addr_valid,
   output logic                 arp_reply_req,
   output logic [15:0]          arp_oper,
   output logic [CNT_WIDTH-1:0] drop_cnt
);

   localparam logic [4:0] c_last_idx = 5'(ARP_BODY_LEN - 1);

   arp_rx_state_t r_state, w_state_next;
   logic [4:0]  r_cnt, w_cnt_next;
   logic        w_accept;
   logic        w_drop_byte;
   logic        w_check_drop;
   logic        w_commit;
   logic [1:0]  w_drop_inc;
   logic [CNT_WIDTH:0] w_drop_sum;

   // Working capture registers (never visible until a commit)
   logic [47:0] r_sha;
   logic [31:0] r_spa;
   logic [31:0] r_tpa;
   logic [15:0] r_oper;
   logic        r_tuser;

   // Presented values, held between commits
   logic [47:0] r_mac_q;
   logic [31:0] r_ip_q;
   logic [15:0] r_oper_q;
   logic [CNT_WIDTH-1:0] r_drop_cnt;

   assign s_axis_tready = aresetn;
   assign w_accept      = s_axis_tvalid & s_axis_tready;

   // Next state, byte counter and commit/drop decisions
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_drop_byte  = 1'b0;
      w_commit     = 1'b0;
      w_check_drop = 1'b0;
      case (r_state)
         IDLE, CHECK: begin
            if (r_state == CHECK) begin
               w_commit     = aresetn & ~r_tuser & (r_spa != 32'd0) & ~r_sha[40];
               w_check_drop = ~w_commit;
               w_state_next = IDLE;
            end
            // A byte here is byte 0 of a new frame, also when in CHECK
            if (w_accept) begin
               w_cnt_next = 5'd0;
               if (s_axis_tlast) begin
                  w_drop_byte  = 1'b1;
                  w_state_next = IDLE;
               end else if (!hdr_byte_ok(5'd0, s_axis_tdata)) begin
                  w_state_next = DROP;
               end else begin
                  w_state_next = PARSE;
                  w_cnt_next   = 5'd1;
               end
            end
         end
         PARSE: begin
            if (w_accept) begin
               if (r_cnt == c_last_idx) begin
                  w_state_next = s_axis_tlast ? CHECK : PAD;
                  w_cnt_next   = 5'd0;
               end else if (s_axis_tlast) begin
                  w_drop_byte  = 1'b1;
                  w_state_next = IDLE;
                  w_cnt_next   = 5'd0;
               end else if (!hdr_byte_ok(r_cnt, s_axis_tdata)) begin
                  w_state_next = DROP;
                  w_cnt_next   = 5'd0;
               end else begin
                  w_cnt_next = r_cnt + 5'd1;
               end
            end
         end
         PAD: begin
            if (w_accept && s_axis_tlast) w_state_next = CHECK;
         end
         DROP: begin
            if (w_accept && s_axis_tlast) begin
               w_drop_byte  = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State and byte counter registers
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state <= IDLE;
         r_cnt   <= 5'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Shift body bytes into the working field registers by offset
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_sha   <= '0;
         r_spa   <= '0;
         r_tpa   <= '0;
         r_oper  <= '0;
         r_tuser <= 1'b0;
      end else if (w_accept) begin
         if (r_state == PARSE) begin
            if (r_cnt == 5'd6 || r_cnt == 5'd7)   r_oper <= {r_oper[7:0], s_axis_tdata};
            if (r_cnt >= 5'd8 && r_cnt <= 5'd13)  r_sha  <= {r_sha[39:0], s_axis_tdata};
            if (r_cnt >= 5'd14 && r_cnt <= 5'd17) r_spa  <= {r_spa[23:0], s_axis_tdata};
            if (r_cnt >= 5'd24)                   r_tpa  <= {r_tpa[23:0], s_axis_tdata};
         end
         if (s_axis_tlast) r_tuser <= s_axis_tuser;
      end
   end

   // Latch the presented addresses on commit
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_mac_q  <= '0;
         r_ip_q   <= '0;
         r_oper_q <= '0;
      end else if (w_commit) begin
         r_mac_q  <= r_sha;
         r_ip_q   <= r_spa;
         r_oper_q <= r_oper;
      end
   end

   // A CHECK drop and a one-byte frame can land in the same cycle
   assign w_drop_inc = {1'b0, w_drop_byte} + {1'b0, w_check_drop};
   assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_WIDTH-1){1'b0}}, w_drop_inc};

   // Saturating dropped-frame counter
   always_ff @(posedge aclk) begin
      if (!aresetn)                r_drop_cnt <= '0;
      else if (w_drop_sum[CNT_WIDTH]) r_drop_cnt <= '1;
      else                         r_drop_cnt <= w_drop_sum[CNT_WIDTH-1:0];
   end

   // The commit cycle shows the fresh fields alongside the strobe
   assign arp_mac_s_addr_valid = w_commit;
   assign arp_mac_s_addr       = w_commit ? r_sha  : r_mac_q;
   assign arp_ip_s_addr        = w_commit ? r_spa  : r_ip_q;
   assign arp_oper             = w_commit ? r_oper : r_oper_q;
   assign arp_reply_req        = w_commit & (r_oper == ARP_OPER_REQ) & (r_tpa == ip_config_addr_in);
   assign drop_cnt             = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arp_rx_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_arp_rx_parser
// Description : Self-checking bench for arp_rx_parser with a frame-level
//               reference model and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arp_rx_parser;

   localparam int CNT_W    = 4;
   localparam int DROP_MAX = (1 << CNT_W) - 1;
   localparam logic [31:0] IP_CFG = 32'hC0A8_0102;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic [31:0]       ip_config_addr_in = IP_CFG;
   logic [7:0]        s_axis_tdata = 8'h00;
   logic              s_axis_tvalid = 1'b0;
   logic              s_axis_tready;
   logic              s_axis_tlast = 1'b0;
   logic              s_axis_tuser = 1'b0;
   logic [47:0]       arp_mac_s_addr;
   logic [31:0]       arp_ip_s_addr;
   logic              arp_mac_s_addr_valid;
   logic              arp_reply_req;
   logic [15:0]       arp_oper;
   logic [CNT_W-1:0]  drop_cnt;

   arp_rx_parser #(.CNT_WIDTH(CNT_W)) dut (
      .aclk                 (aclk),
      .aresetn              (aresetn),
      .ip_config_addr_in    (ip_config_addr_in),
      .s_axis_tdata         (s_axis_tdata),
      .s_axis_tvalid        (s_axis_tvalid),
      .s_axis_tready        (s_axis_tready),
      .s_axis_tlast         (s_axis_tlast),
      .s_axis_tuser         (s_axis_tuser),
      .arp_mac_s_addr       (arp_mac_s_addr),
      .arp_ip_s_addr        (arp_ip_s_addr),
      .arp_mac_s_addr_valid (arp_mac_s_addr_valid),
      .arp_reply_req        (arp_reply_req),
      .arp_oper             (arp_oper),
      .drop_cnt             (drop_cnt)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge aclk) cyc <= cyc + 1;

   // Strobe monitor
   int          strobe_cnt = 0;
   int          orphan_reply = 0;
   logic [47:0] cap_mac = '0;
   logic [31:0] cap_ip = '0;
   logic [15:0] cap_oper = '0;
   logic        cap_reply = 1'b0;
   int          cap_cyc = 0;

   always @(negedge aclk) begin
      if (arp_mac_s_addr_valid === 1'b1) begin
         strobe_cnt = strobe_cnt + 1;
         cap_mac    = arp_mac_s_addr;
         cap_ip     = arp_ip_s_addr;
         cap_oper   = arp_oper;
         cap_reply  = arp_reply_req;
         cap_cyc    = cyc;
      end else if (arp_reply_req === 1'b1) begin
         orphan_reply = orphan_reply + 1;
      end
   end

   // Stimulus queue
   typedef struct {
      logic [7:0] d;
      bit         last;
      bit         user;
   } beat_t;
   beat_t tx_q[$];

   // Reference model: judges each complete frame as a whole
   logic [7:0]  m_bytes[$];
   int          exp_strobes = 0;
   int          exp_drop = 0;
   logic [47:0] exp_mac = '0;
   logic [31:0] exp_ip = '0;
   logic [15:0] exp_oper = '0;
   logic        exp_reply = 1'b0;
   int          exp_cyc = 0;

   task automatic model_frame(input bit user, input int at_cyc);
      bit          ok;
      logic [47:0] sha;
      logic [31:0] spa, tpa;
      logic [15:0] oper;
      ok = (m_bytes.size() >= 28);
      if (ok) begin
         oper = {m_bytes[6], m_bytes[7]};
         sha  = {m_bytes[8], m_bytes[9], m_bytes[10], m_bytes[11], m_bytes[12], m_bytes[13]};
         spa  = {m_bytes[14], m_bytes[15], m_bytes[16], m_bytes[17]};
         tpa  = {m_bytes[24], m_bytes[25], m_bytes[26], m_bytes[27]};
         if ({m_bytes[0], m_bytes[1]} != 16'h0001) ok = 0;
         if ({m_bytes[2], m_bytes[3]} != 16'h0800) ok = 0;
         if (m_bytes[4] != 8'd6 || m_bytes[5] != 8'd4) ok = 0;
         if (oper != 16'd1 && oper != 16'd2) ok = 0;
         if (user || spa == 32'd0 || sha[40]) ok = 0;
      end
      if (ok) begin
         exp_strobes++;
         exp_mac   = sha;
         exp_ip    = spa;
         exp_oper  = oper;
         exp_reply = (oper == 16'd1) && (tpa == ip_config_addr_in);
         exp_cyc   = at_cyc;
      end else if (exp_drop < DROP_MAX) begin
         exp_drop++;
      end
   endtask

   task automatic build_arp(input logic [15:0] oper, input logic [47:0] sha,
                            input logic [31:0] spa, input logic [31:0] tpa,
                            input logic [15:0] ptype, input int len,
                            input bit user, input int cidx);
      logic [7:0] b[$];
      b.push_back(8'h00); b.push_back(8'h01);
      b.push_back(ptype[15:8]); b.push_back(ptype[7:0]);
      b.push_back(8'h06); b.push_back(8'h04);
      b.push_back(oper[15:8]); b.push_back(oper[7:0]);
      for (int i = 5; i >= 0; i--) b.push_back(sha[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) b.push_back(spa[i*8 +: 8]);
      for (int i = 0; i < 6; i++)  b.push_back(8'h00);
      for (int i = 3; i >= 0; i--) b.push_back(tpa[i*8 +: 8]);
      while (b.size() < len) b.push_back(8'($urandom));
      while (b.size() > len) void'(b.pop_back());
      if (cidx >= 0 && cidx < b.size()) b[cidx] = b[cidx] ^ 8'h10;
      for (int i = 0; i < len; i++)
         tx_q.push_back('{d: b[i], last: (i == len - 1), user: (i == len - 1) ? user : 1'b0});
   endtask

   // Sends up to nmax queued beats with random idle cycles in between
   task automatic send_beats(input int gap_pct, input int nmax);
      beat_t bt;
      int    n;
      n = 0;
      while (tx_q.size() > 0 && n < nmax) begin
         bt = tx_q.pop_front();
         while ($urandom_range(99) < gap_pct) begin
            s_axis_tvalid = 1'b0;
            @(posedge aclk); #1;
         end
         s_axis_tdata  = bt.d;
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = bt.last;
         s_axis_tuser  = bt.user;
         @(posedge aclk); #1;
         m_bytes.push_back(bt.d);
         if (bt.last) begin
            model_frame(bt.user, cyc);
            m_bytes.delete();
         end
         n++;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
   endtask

   task automatic apply_reset();
      s_axis_tvalid = 1'b0;
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      exp_drop = 0; exp_mac = '0; exp_ip = '0; exp_oper = '0;
      m_bytes.delete();
      aresetn = 1'b1;
   endtask

   task automatic settle();
      repeat (3) @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
      checks++;
      if ({arp_mac_s_addr, arp_ip_s_addr, arp_oper, arp_mac_s_addr_valid, arp_reply_req} !== '0 || drop_cnt !== '0) begin
         errors++;
         $display("FAIL reset_outputs: mac=%h ip=%h oper=%h v=%b rr=%b drop=%0d want all 0",
                  arp_mac_s_addr, arp_ip_s_addr, arp_oper, arp_mac_s_addr_valid, arp_reply_req, drop_cnt);
      end
      aresetn = 1'b1;
      #1;
      checks++;
      if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", s_axis_tready); end
   endtask

   task automatic test_request();
      build_arp(16'h0001, 48'h02_00_00_00_00_0A, 32'hC0A8_010A, IP_CFG, 16'h0800, 46, 1'b0, -1);
      send_beats(0, 1000);
      settle();
      checks++;
      if (strobe_cnt != 1) begin errors++; $display("FAIL req_strobes: got %0d want 1", strobe_cnt); end
      checks++;
      if (cap_mac !== 48'h02_00_00_00_00_0A || cap_ip !== 32'hC0A8_010A) begin
         errors++; $display("FAIL req_addr: got %h/%h want 02000000000a/c0a8010a", cap_mac, cap_ip);
      end
      checks++;
      if (cap_reply !== 1'b1 || cap_oper !== 16'h0001) begin
         errors++; $display("FAIL req_reply: got rr=%b oper=%h want 1/0001", cap_reply, cap_oper);
      end
      checks++;
      if (cap_cyc != exp_cyc) begin errors++; $display("FAIL req_latency: got cycle %0d want %0d", cap_cyc, exp_cyc); end
      checks++;
      if (drop_cnt !== 4'd0 || arp_mac_s_addr !== 48'h02_00_00_00_00_0A || arp_oper !== 16'h0001) begin
         errors++; $display("FAIL req_hold: drop=%0d mac=%h oper=%h want 0/02000000000a/0001", drop_cnt, arp_mac_s_addr, arp_oper);
      end
   endtask

   task automatic test_reply();
      logic [47:0] sha;
      logic [31:0] spa;
      sha = {16'($urandom), $urandom};
      sha[40] = 1'b0;
      spa = $urandom | 32'h1;
      build_arp(16'h0002, sha, spa, IP_CFG, 16'h0800, 28, 1'b0, -1);
      send_beats(0, 1000);
      settle();
      checks++;
      if (strobe_cnt != exp_strobes) begin errors++; $display("FAIL rep_strobes: got %0d want %0d", strobe_cnt, exp_strobes); end
      checks++;
      if (cap_mac !== sha || cap_ip !== spa || cap_reply !== 1'b0 || cap_cyc != exp_cyc) begin
         errors++; $display("FAIL rep_capture: got %h/%h rr=%b cyc=%0d want %h/%h rr=0 cyc=%0d",
                            cap_mac, cap_ip, cap_reply, cap_cyc, sha, spa, exp_cyc);
      end
      checks++;
      if (arp_mac_s_addr !== sha || arp_ip_s_addr !== spa || arp_oper !== 16'h0002) begin
         errors++; $display("FAIL rep_hold: got %h/%h/%h want %h/%h/0002", arp_mac_s_addr, arp_ip_s_addr, arp_oper, sha, spa);
      end
   endtask

   task automatic test_bad_ptype();
      build_arp(16'h0001, 48'h02_11_22_33_44_55, 32'h0A00_0001, IP_CFG, 16'h86DD, 46, 1'b0, -1);
      send_beats(0, 1000);
      settle();
      checks++;
      if (strobe_cnt != exp_strobes || drop_cnt !== 4'd1) begin
         errors++; $display("FAIL ptype_drop: strobes=%0d drop=%0d want %0d/1", strobe_cnt, drop_cnt, exp_strobes);
      end
      checks++;
      if (arp_mac_s_addr !== exp_mac || arp_ip_s_addr !== exp_ip) begin
         errors++; $display("FAIL ptype_hold: got %h/%h want %h/%h", arp_mac_s_addr, arp_ip_s_addr, exp_mac, exp_ip);
      end
   endtask

   task automatic test_truncated_back_to_back();
      build_arp(16'h0001, 48'h02_AA_BB_CC_DD_EE, 32'h0A00_0002, IP_CFG, 16'h0800, 21, 1'b0, -1);
      build_arp(16'h0001, 48'h04_01_02_03_04_05, 32'h0A00_0003, IP_CFG, 16'h0800, 28, 1'b0, -1);
      send_beats(0, 1000);
      settle();
      checks++;
      if (drop_cnt !== 4'(exp_drop) || drop_cnt !== 4'd2) begin
         errors++; $display("FAIL trunc_drop: got %0d want 2", drop_cnt);
      end
      checks++;
      if (strobe_cnt != exp_strobes || cap_mac !== 48'h04_01_02_03_04_05 || cap_ip !== 32'h0A00_0003 || cap_reply !== 1'b1) begin
         errors++; $display("FAIL b2b_commit: strobes=%0d mac=%h ip=%h rr=%b want %0d/040102030405/0a000003/1",
                            strobe_cnt, cap_mac, cap_ip, cap_reply, exp_strobes);
      end
   endtask

   task automatic test_tuser_and_probe();
      build_arp(16'h0001, 48'h02_00_00_00_00_77, 32'h0A00_0009, IP_CFG, 16'h0800, 46, 1'b1, -1);
      build_arp(16'h0001, 48'h02_00_00_00_00_78, 32'h0000_0000, IP_CFG, 16'h0800, 46, 1'b0, -1);
      send_beats(0, 1000);
      settle();
      checks++;
      if (strobe_cnt != exp_strobes || drop_cnt !== 4'd4) begin
         errors++; $display("FAIL tuser_probe: strobes=%0d drop=%0d want %0d/4", strobe_cnt, drop_cnt, exp_strobes);
      end
   endtask

   task automatic test_gaps_and_reset();
      logic [47:0] sha;
      sha = {16'($urandom), $urandom};
      sha[40] = 1'b0;
      build_arp(16'h0001, sha, 32'hC0A8_0164, IP_CFG, 16'h0800, 40, 1'b0, -1);
      send_beats(50, 1000);
      settle();
      checks++;
      if (strobe_cnt != exp_strobes || cap_mac !== sha || cap_ip !== 32'hC0A8_0164 || cap_reply !== 1'b1 || cap_cyc != exp_cyc) begin
         errors++; $display("FAIL gap_commit: strobes=%0d mac=%h rr=%b cyc=%0d want %0d/%h/1/%0d",
                            strobe_cnt, cap_mac, cap_reply, cap_cyc, exp_strobes, sha, exp_cyc);
      end
      // Reset in the middle of a frame; the tail is then seen as its own frame
      build_arp(16'h0001, 48'h02_00_00_00_00_31, 32'h0A01_0101, IP_CFG, 16'h0800, 28, 1'b0, -1);
      send_beats(0, 10);
      apply_reset();
      checks++;
      if ({arp_mac_s_addr, arp_ip_s_addr, arp_oper} !== '0 || drop_cnt !== '0) begin
         errors++; $display("FAIL midreset_outputs: mac=%h ip=%h oper=%h drop=%0d want 0", arp_mac_s_addr, arp_ip_s_addr, arp_oper, drop_cnt);
      end
      send_beats(0, 1000);
      build_arp(16'h0002, 48'h02_00_00_00_00_32, 32'h0A01_0102, 32'h0A01_0199, 16'h0800, 28, 1'b0, -1);
      send_beats(0, 1000);
      settle();
      checks++;
      if (strobe_cnt != exp_strobes || drop_cnt !== 4'(exp_drop) || arp_mac_s_addr !== 48'h02_00_00_00_00_32 || arp_oper !== 16'h0002) begin
         errors++; $display("FAIL after_reset: strobes=%0d drop=%0d mac=%h oper=%h want %0d/%0d/020000000032/0002",
                            strobe_cnt, drop_cnt, arp_mac_s_addr, arp_oper, exp_strobes, exp_drop);
      end
   endtask

   task automatic test_random_frames();
      logic [15:0] oper;
      logic [47:0] sha;
      logic [31:0] spa, tpa;
      int len, cidx;
      bit user;
      apply_reset();
      for (int f = 0; f < 14; f++) begin
         oper = ($urandom_range(5) == 0) ? 16'h0003 : (($urandom_range(1) == 0) ? 16'h0001 : 16'h0002);
         sha  = {16'($urandom), $urandom};
         sha[40] = ($urandom_range(9) == 0);
         spa  = ($urandom_range(9) == 0) ? 32'd0 : $urandom;
         tpa  = ($urandom_range(1) == 0) ? IP_CFG : $urandom;
         len  = ($urandom_range(9) == 0) ? int'($urandom_range(27, 1)) : 28 + int'($urandom_range(18));
         cidx = ($urandom_range(5) == 0) ? int'($urandom_range(7)) : -1;
         user = ($urandom_range(7) == 0);
         build_arp(oper, sha, spa, tpa, 16'h0800, len, user, cidx);
      end
      send_beats(30, 100000);
      settle();
      checks++;
      if (strobe_cnt != exp_strobes || drop_cnt !== 4'(exp_drop)) begin
         errors++; $display("FAIL rand_counts: strobes=%0d drop=%0d want %0d/%0d", strobe_cnt, drop_cnt, exp_strobes, exp_drop);
      end
      checks++;
      if (arp_mac_s_addr !== exp_mac || arp_ip_s_addr !== exp_ip || arp_oper !== exp_oper) begin
         errors++; $display("FAIL rand_hold: got %h/%h/%h want %h/%h/%h", arp_mac_s_addr, arp_ip_s_addr, arp_oper, exp_mac, exp_ip, exp_oper);
      end
      checks++;
      if (cap_reply !== exp_reply || cap_cyc != exp_cyc) begin
         errors++; $display("FAIL rand_last_strobe: rr=%b cyc=%0d want %b/%0d", cap_reply, cap_cyc, exp_reply, exp_cyc);
      end
      checks++;
      if (orphan_reply != 0) begin errors++; $display("FAIL reply_without_valid: got %0d want 0", orphan_reply); end
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int i = 0; i < 12; i++) tx_q.push_back('{d: 8'h00, last: 1'b1, user: 1'b0});
      send_beats(0, 1000);
      settle();
      checks++;
      if (drop_cnt !== 4'd12) begin errors++; $display("FAIL drop_count_12: got %0d want 12", drop_cnt); end
      // Valid frame ending at byte 27, then one-byte frames straight through CHECK
      build_arp(16'h0001, 48'h02_00_00_00_00_55, 32'h0A00_0055, IP_CFG, 16'h0800, 28, 1'b1, -1);
      for (int i = 0; i < 6; i++) tx_q.push_back('{d: 8'h00, last: 1'b1, user: 1'b0});
      send_beats(0, 1000);
      settle();
      checks++;
      if (drop_cnt !== 4'(DROP_MAX) || drop_cnt !== 4'(exp_drop)) begin
         errors++; $display("FAIL drop_saturate: got %0d want %0d", drop_cnt, DROP_MAX);
      end
      checks++;
      if (strobe_cnt != exp_strobes) begin errors++; $display("FAIL sat_strobes: got %0d want %0d", strobe_cnt, exp_strobes); end
   endtask

   initial begin
      test_reset();
      test_request();
      test_reply();
      test_bad_ptype();
      test_truncated_back_to_back();
      test_tuser_and_probe();
      test_gaps_and_reset();
      test_random_frames();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arp_rx_parser.md
Name: arp_rx_parser

Overview:
- Byte-serial ARP packet parser on the RX path, directly upstream of the ARP cache.
- Consumes the Ethernet payload of frames whose EtherType is 0x0806 (MAC header already stripped) as an 8-bit AXI-Stream.
- Validates the 28-byte IPv4-over-Ethernet ARP body and emits sender MAC/IP plus a one-cycle valid strobe to the cache.
- Also flags ARP requests addressed to the local IP so the TX side can schedule a reply.

Parameters:
CNT_WIDTH, 16, width of the dropped-frame statistics counter (saturating).

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
ip_config_addr_in  input  32  local IPv4 address, compared against TPA
s_axis_tdata  input  8  payload byte, network order (first byte = HTYPE MSB)
s_axis_tvalid  input  1  byte valid
s_axis_tready  output  1  parser ready; constant 1 when out of reset
s_axis_tlast  input  1  last payload byte of the frame
s_axis_tuser  input  1  frame error (FCS/PHY), sampled with tlast
arp_mac_s_addr  output  48  sender hardware address (SHA)
arp_ip_s_addr  output  32  sender protocol address (SPA)
arp_mac_s_addr_valid  output  1  one-cycle strobe: SHA/SPA valid for caching
arp_reply_req  output  1  one-cycle strobe, coincident with valid: OPER=1 and TPA==ip_config_addr_in
arp_oper  output  16  OPER of the last accepted packet
drop_cnt  output  CNT_WIDTH  frames discarded, saturating

Behaviour:
- Reset: aresetn is synchronous, active-low; clock is aclk. Reset forces state IDLE and byte counter 0. All outputs are 0, except s_axis_tready=0 while aresetn=0.
- A byte is accepted on any cycle with tvalid&tready. When tvalid=0 the counter and state hold.
- States:
  - IDLE: on the first accepted byte, store it as byte 0, set cnt=1, go to PARSE. If that byte also has tlast, count a drop and stay in IDLE.
  - PARSE: store byte[cnt] into the shift/field registers and increment cnt.
    - Header check is per byte: bytes 0-1 = 0x0001, 2-3 = 0x0800, 4 = 0x06, 5 = 0x04, 6-7 OPER in {1,2}.
    - Any mismatch goes to DROP (or straight to IDLE with a drop count if that byte has tlast).
    - tlast with cnt<27 (short frame): drop, go to IDLE.
    - Byte 27 accepted: go to CHECK if tlast, else PAD.
  - PAD: discard bytes (Ethernet padding up to 46 bytes total) until tlast, then go to CHECK.
  - DROP: discard until tlast, increment drop_cnt, go to IDLE.
  - CHECK (single cycle, no byte consumed, tready stays 1): commit or drop, then go to IDLE. A byte arriving in CHECK is treated as byte 0 of the next frame, identical to IDLE.
- Commit conditions: tuser=0 on the tlast beat; SPA != 0.0.0.0 (probe); SHA bit 40 = 0 (unicast sender).
  - On commit: arp_mac_s_addr/arp_ip_s_addr/arp_oper update and arp_mac_s_addr_valid=1 for exactly one cycle.
  - Otherwise: drop_cnt+1 and no strobe.
- Latency: strobe is asserted in the cycle after the tlast beat is accepted.
- Address outputs are updated only on commit and hold their value between frames.
- Working capture registers are separate from the outputs, so a partially parsed frame never disturbs the presented addresses.
- arp_reply_req = commit & OPER==0x0001 & TPA==ip_config_addr_in. ip_config_addr_in is sampled in CHECK.
- drop_cnt saturates at all-ones and does not wrap.
- Reset mid-frame: the parser returns to IDLE and the rest of the frame is parsed as a new frame. Upstream shares aresetn, so this case is not expected in normal operation.

Decomposition:
- eth_pkg holds: ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_HLEN=8'd6, ARP_PLEN=8'd4, ARP_OPER_REQ=16'h0001, ARP_OPER_REP=16'h0002, ARP_BODY_LEN=28, and the arp_rx_state_t enum {IDLE, PARSE, PAD, DROP, CHECK}.
- No sub-module: one FSM, a 5-bit byte counter and the field registers.

Test Plan:
- Request, SHA=02:00:00:00:00:0A, SPA=192.168.1.10, TPA=ip_config_addr_in=192.168.1.2, 18 pad bytes then tlast -> one strobe 1 cycle after tlast, addresses as sent, arp_reply_req=1, arp_oper=0x0001, drop_cnt=0.
- Reply (OPER=2), tlast on byte 27, no padding -> strobe, arp_reply_req=0; previous outputs overwritten.
- PTYPE=0x86DD, tlast at byte 45 -> no strobe, drop_cnt=1, outputs unchanged.
- Frame truncated, tlast at byte 20 -> no strobe, drop_cnt+1; the next back-to-back valid frame parsed correctly.
- Valid body, tuser=1 on tlast; and separately SPA=0.0.0.0 -> no strobe, drop_cnt+2 total.
- Random tvalid gaps (50%) inside a valid request; aresetn pulsed mid-frame, then a clean frame -> stall-tolerant parse; after reset, outputs=0 and the clean frame commits normally.
